ahb_bus_arbiter: RTL and testbench
==================================

# ahb_bus_arbiter

Two-master AHB-Lite arbiter merging the core's instruction-fetch port and LSU data port onto one shared AHB master port, for systems with a single memory bus. Sits between the hardisc top-level bus outputs and the system interconnect. Buffers a losing address phase, stalls the losing master through its hready, and routes responses to the data-phase owner. Checksum and parity sidebands travel with their phase.

## Interface
- No parameters.
- s_clk_i  in  1  clock, single domain
- s_resetn_i  in  1  asynchronous active-low reset
- s_i_haddr_i / s_d_haddr_i  in  32  address, fetch / data master
- s_i_htrans_i / s_d_htrans_i  in  2  transfer type
- s_i_hwrite_i / s_d_hwrite_i  in  1  write
- s_i_hsize_i / s_d_hsize_i  in  3  size
- s_i_hparity_i / s_d_hparity_i  in  6  address-phase parity
- s_d_hwdata_i  in  32  write data (data master only)
- s_d_hwchecksum_i  in  7  write-data checksum
- s_i_hready_o / s_d_hready_o  out  1  per-master ready
- s_i_hresp_o / s_d_hresp_o  out  1  per-master error response
- s_hrdata_o  out  32  read data, broadcast to both masters
- s_hrchecksum_o  out  7  read checksum, broadcast
- s_m_haddr_o, s_m_htrans_o, s_m_hwrite_o, s_m_hsize_o, s_m_hparity_o  out  32/2/1/3/6  shared address phase
- s_m_hwdata_o  out  32, s_m_hwchecksum_o  out  7  shared data phase
- s_m_hrdata_i  in  32, s_m_hrchecksum_i  in  7, s_m_hready_i  in  1, s_m_hresp_i  in  1  shared response

## Operation
- Request: htrans[1]=1 while the master's own hready_o=1 (address accepted from the master's view).
- Per-port pending register (addr, write, size, parity, valid); at most one per port.
- Candidate per port: pending if valid, else live request.
- Grant issued only when s_m_hready_i=1; at most one per cycle. Otherwise s_m_htrans_o=IDLE (2'b00), address fields 0.
- Conflict (both candidates): data port wins (fixed priority, see Configuration).
- Granted candidate drives the M address phase combinationally with htrans=NONSEQ; its pending valid clears.
- Losing live request, or any live request while s_m_hready_i=0, is captured into pending.
- Owner register {NONE, I, D}: on s_m_hready_i=1 loads grantee, or NONE if no grant.
- Per-port hready_o: s_m_hready_i if owner; 0 if pending valid or granted from pending this cycle; else 1.
- hresp_o: s_m_hresp_i if owner, else 0. Two-cycle ERROR passes through unchanged; arbiter never cancels pending requests.
- s_m_hwdata_o/s_m_hwchecksum_o: data-master inputs when owner=D, else 0.
- hrdata/hrchecksum forwarded unconditionally; only owner samples.
- Reset: owner NONE, pending cleared, last-grant I, s_m_htrans_o IDLE, both hready_o 1, both hresp_o 0.

## Timing
- Uncontended, bus ready: zero added latency; M address phase in the same cycle as the master's.
- Lost arbitration: one stall cycle minimum; pending re-issued next cycle with s_m_hready_i=1, master sees hready_o=0 until its M data phase completes.
- Back-to-back from one master: a new address accepted in the same cycle its data phase completes.
- Simultaneous capture and grant of the other port are legal in one cycle.
- Reset mid-transfer: all state cleared asynchronously; in-flight M data phase abandoned.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on conflict the port not granted last wins; last-grant register updates on every grant.
- Undefined: fixed priority, data port wins; last-grant register not instantiated.

## Structure
- p_hardisc gains: ahb_owner_t enum {OWN_NONE, OWN_I, OWN_D}; HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10; ahb_areq_t struct (haddr, hwrite, hsize, hparity).
- Sub-module ahb_arb_req_buffer: per-port pending register with capture/clear and candidate mux; instantiated twice.

## Test plan
- I reads 0x100 alone, s_m_hready_i=1 -> s_m_haddr_o=0x100, NONSEQ same cycle; next cycle owner I, s_i_hready_o follows bus.
- I 0x200 and D write 0x8000 same cycle -> D granted; I pending, s_i_hready_o=0; next cycle s_m_haddr_o=0x200; D write data driven while owner D.
- Same with ARB_ROUND_ROBIN_EN, last grant D -> I 0x200 granted first, D 0x8000 one cycle later.
- D request while s_m_hready_i=0 for 3 cycles -> s_m_htrans_o IDLE those cycles; D issued the first cycle hready returns.
- M returns ERROR (hresp=1 with hready 0 then 1) for D read -> s_d_hresp_o=1 both cycles, s_i_hresp_o=0; pending I still issued afterward.
- Reset asserted with I pending -> pending cleared, s_i_hready_o=1, s_m_htrans_o=IDLE immediately.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master AHB-Lite arbiter.
package ahb_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CSUM_W  = 7;
  localparam int unsigned PAR_W   = 6;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned TRANS_W = 2;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } ahb_owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [SIZE_W-1:0] hsize;
    logic [PAR_W-1:0]  hparity;
  } ahb_areq_t;

endpackage

// File: rtl/ahb_arb_req_buffer.sv
// Per-port pending address-phase register plus the pending/live candidate mux.
module ahb_arb_req_buffer
  import ahb_bus_arbiter_pkg::*;
(
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  input  logic      live_valid,
  input  ahb_areq_t live_req,
  input  logic      grant,
  output logic      cand_valid_c,
  output ahb_areq_t cand_req_c,
  output logic      pend_valid
);

  ahb_areq_t pend_q;
  logic      pend_valid_q;

  // A live request that is not granted this cycle is held until it is.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else if (grant) begin
      pend_valid_q <= 1'b0;
    end else if (live_valid) begin
      pend_valid_q <= 1'b1;
      pend_q       <= live_req;
    end
  end

  assign cand_valid_c = pend_valid_q | live_valid;
  assign cand_req_c   = pend_valid_q ? pend_q : live_req;
  assign pend_valid   = pend_valid_q;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter (fetch + LSU onto one master port).
// Optional macro ARB_ROUND_ROBIN_EN: alternate winner on conflict instead of data-port priority.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
(
  input  logic                s_clk_i,
  input  logic                s_resetn_i,
  input  logic [ADDR_W-1:0]   s_i_haddr_i,
  input  logic [TRANS_W-1:0]  s_i_htrans_i,
  input  logic                s_i_hwrite_i,
  input  logic [SIZE_W-1:0]   s_i_hsize_i,
  input  logic [PAR_W-1:0]    s_i_hparity_i,
  input  logic [ADDR_W-1:0]   s_d_haddr_i,
  input  logic [TRANS_W-1:0]  s_d_htrans_i,
  input  logic                s_d_hwrite_i,
  input  logic [SIZE_W-1:0]   s_d_hsize_i,
  input  logic [PAR_W-1:0]    s_d_hparity_i,
  input  logic [DATA_W-1:0]   s_d_hwdata_i,
  input  logic [CSUM_W-1:0]   s_d_hwchecksum_i,
  output logic                s_i_hready_o,
  output logic                s_d_hready_o,
  output logic                s_i_hresp_o,
  output logic                s_d_hresp_o,
  output logic [DATA_W-1:0]   s_hrdata_o,
  output logic [CSUM_W-1:0]   s_hrchecksum_o,
  output logic [ADDR_W-1:0]   s_m_haddr_o,
  output logic [TRANS_W-1:0]  s_m_htrans_o,
  output logic                s_m_hwrite_o,
  output logic [SIZE_W-1:0]   s_m_hsize_o,
  output logic [PAR_W-1:0]    s_m_hparity_o,
  output logic [DATA_W-1:0]   s_m_hwdata_o,
  output logic [CSUM_W-1:0]   s_m_hwchecksum_o,
  input  logic [DATA_W-1:0]   s_m_hrdata_i,
  input  logic [CSUM_W-1:0]   s_m_hrchecksum_i,
  input  logic                s_m_hready_i,
  input  logic                s_m_hresp_i
);

  ahb_owner_t owner_q, owner_d;
  ahb_areq_t  i_live_req, d_live_req, i_cand_req_c, d_cand_req_c, m_req_c;
  logic       i_hready_c, d_hready_c, i_live_c, d_live_c;
  logic       i_cand_c, d_cand_c, i_pend, d_pend;
  logic       grant_i_c, grant_d_c, d_wins_c;
  logic       unused_htrans;

  // Only htrans[1] distinguishes a request; BUSY/SEQ are not forwarded.
  assign unused_htrans = ^{s_i_htrans_i[0], s_d_htrans_i[0]};

  assign i_live_req = '{haddr: s_i_haddr_i, hwrite: s_i_hwrite_i,
                        hsize: s_i_hsize_i, hparity: s_i_hparity_i};
  assign d_live_req = '{haddr: s_d_haddr_i, hwrite: s_d_hwrite_i,
                        hsize: s_d_hsize_i, hparity: s_d_hparity_i};

  // A port with a buffered address is stalled until its own data phase runs.
  assign i_hready_c = (owner_q == OWN_I) ? s_m_hready_i : ~i_pend;
  assign d_hready_c = (owner_q == OWN_D) ? s_m_hready_i : ~d_pend;
  assign i_live_c   = s_i_htrans_i[1] & i_hready_c;
  assign d_live_c   = s_d_htrans_i[1] & d_hready_c;

  ahb_arb_req_buffer u_i_buf (
    .s_clk_i      (s_clk_i),
    .s_resetn_i   (s_resetn_i),
    .live_valid   (i_live_c),
    .live_req     (i_live_req),
    .grant        (grant_i_c),
    .cand_valid_c (i_cand_c),
    .cand_req_c   (i_cand_req_c),
    .pend_valid   (i_pend)
  );

  ahb_arb_req_buffer u_d_buf (
    .s_clk_i      (s_clk_i),
    .s_resetn_i   (s_resetn_i),
    .live_valid   (d_live_c),
    .live_req     (d_live_req),
    .grant        (grant_d_c),
    .cand_valid_c (d_cand_c),
    .cand_req_c   (d_cand_req_c),
    .pend_valid   (d_pend)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Remembers which port was granted most recently; reset means fetch.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      last_d_q <= 1'b0;
    end else if (grant_i_c | grant_d_c) begin
      last_d_q <= grant_d_c;
    end
  end

  assign d_wins_c = ~last_d_q;
`else
  assign d_wins_c = 1'b1;
`endif

  // At most one grant per cycle, and only when the shared bus accepts an address.
  always_comb begin
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    if (s_m_hready_i) begin
      if (i_cand_c && d_cand_c) begin
        grant_d_c = d_wins_c;
        grant_i_c = ~d_wins_c;
      end else begin
        grant_i_c = i_cand_c;
        grant_d_c = d_cand_c;
      end
    end
  end

  always_comb begin
    m_req_c      = '0;
    s_m_htrans_o = HTRANS_IDLE;
    if (grant_d_c) begin
      m_req_c      = d_cand_req_c;
      s_m_htrans_o = HTRANS_NONSEQ;
    end else if (grant_i_c) begin
      m_req_c      = i_cand_req_c;
      s_m_htrans_o = HTRANS_NONSEQ;
    end
  end

  assign s_m_haddr_o   = m_req_c.haddr;
  assign s_m_hwrite_o  = m_req_c.hwrite;
  assign s_m_hsize_o   = m_req_c.hsize;
  assign s_m_hparity_o = m_req_c.hparity;

  // Data-phase owner tracking.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (s_m_hready_i) begin
      if (grant_d_c) begin
        owner_d = OWN_D;
      end else if (grant_i_c) begin
        owner_d = OWN_I;
      end else begin
        owner_d = OWN_NONE;
      end
    end
  end

  assign s_i_hready_o     = i_hready_c;
  assign s_d_hready_o     = d_hready_c;
  assign s_i_hresp_o      = (owner_q == OWN_I) ? s_m_hresp_i : 1'b0;
  assign s_d_hresp_o      = (owner_q == OWN_D) ? s_m_hresp_i : 1'b0;
  assign s_m_hwdata_o     = (owner_q == OWN_D) ? s_d_hwdata_i : '0;
  assign s_m_hwchecksum_o = (owner_q == OWN_D) ? s_d_hwchecksum_i : '0;
  assign s_hrdata_o       = s_m_hrdata_i;
  assign s_hrchecksum_o   = s_m_hrchecksum_i;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed plus randomized bench for ahb_bus_arbiter against a per-master transaction model.
module tb_ahb_bus_arbiter;

  logic        clk = 1'b0;
  logic        s_resetn_i;
  logic [31:0] s_i_haddr_i, s_d_haddr_i, s_d_hwdata_i, s_m_hrdata_i;
  logic [1:0]  s_i_htrans_i, s_d_htrans_i;
  logic        s_i_hwrite_i, s_d_hwrite_i;
  logic [2:0]  s_i_hsize_i, s_d_hsize_i;
  logic [5:0]  s_i_hparity_i, s_d_hparity_i;
  logic [6:0]  s_d_hwchecksum_i, s_m_hrchecksum_i;
  logic        s_m_hready_i, s_m_hresp_i;
  logic        s_i_hready_o, s_d_hready_o, s_i_hresp_o, s_d_hresp_o;
  logic [31:0] s_hrdata_o, s_m_haddr_o, s_m_hwdata_o;
  logic [6:0]  s_hrchecksum_o, s_m_hwchecksum_o;
  logic [1:0]  s_m_htrans_o;
  logic        s_m_hwrite_o;
  logic [2:0]  s_m_hsize_o;
  logic [5:0]  s_m_hparity_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter dut (
    .s_clk_i          (clk),
    .s_resetn_i       (s_resetn_i),
    .s_i_haddr_i      (s_i_haddr_i),
    .s_i_htrans_i     (s_i_htrans_i),
    .s_i_hwrite_i     (s_i_hwrite_i),
    .s_i_hsize_i      (s_i_hsize_i),
    .s_i_hparity_i    (s_i_hparity_i),
    .s_d_haddr_i      (s_d_haddr_i),
    .s_d_htrans_i     (s_d_htrans_i),
    .s_d_hwrite_i     (s_d_hwrite_i),
    .s_d_hsize_i      (s_d_hsize_i),
    .s_d_hparity_i    (s_d_hparity_i),
    .s_d_hwdata_i     (s_d_hwdata_i),
    .s_d_hwchecksum_i (s_d_hwchecksum_i),
    .s_i_hready_o     (s_i_hready_o),
    .s_d_hready_o     (s_d_hready_o),
    .s_i_hresp_o      (s_i_hresp_o),
    .s_d_hresp_o      (s_d_hresp_o),
    .s_hrdata_o       (s_hrdata_o),
    .s_hrchecksum_o   (s_hrchecksum_o),
    .s_m_haddr_o      (s_m_haddr_o),
    .s_m_htrans_o     (s_m_htrans_o),
    .s_m_hwrite_o     (s_m_hwrite_o),
    .s_m_hsize_o      (s_m_hsize_o),
    .s_m_hparity_o    (s_m_hparity_o),
    .s_m_hwdata_o     (s_m_hwdata_o),
    .s_m_hwchecksum_o (s_m_hwchecksum_o),
    .s_m_hrdata_i     (s_m_hrdata_i),
    .s_m_hrchecksum_i (s_m_hrchecksum_i),
    .s_m_hready_i     (s_m_hready_i),
    .s_m_hresp_i      (s_m_hresp_i)
  );

  // Model: index 0 = fetch master, 1 = data master; owner -1 means nobody.
  int          own;
  int          last;
  int          win;
  bit          pv[2];
  logic [31:0] pa[2];
  logic        pw[2];
  logic [2:0]  ps[2];
  logic [5:0]  pp[2];
  bit          live[2];
  logic [31:0] ad[2];
  logic        wr[2];
  logic [2:0]  sz[2];
  logic [5:0]  par[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own  = -1;
    last = 0;
    for (int p = 0; p < 2; p++) pv[p] = 1'b0;
  endtask

  task automatic idle_inputs();
    s_i_htrans_i = 2'b00; s_d_htrans_i = 2'b00;
    s_i_haddr_i = '0; s_d_haddr_i = '0;
    s_i_hwrite_i = 1'b0; s_d_hwrite_i = 1'b0;
    s_i_hsize_i = '0; s_d_hsize_i = '0;
    s_i_hparity_i = '0; s_d_hparity_i = '0;
    s_d_hwdata_i = '0; s_d_hwchecksum_i = '0;
    s_m_hready_i = 1'b1; s_m_hresp_i = 1'b0;
    s_m_hrdata_i = '0; s_m_hrchecksum_i = '0;
  endtask

  // Settle, derive what the bus should look like this cycle, compare everything.
  task automatic check_now();
    logic [1:0]  ht[2];
    bit          rdy[2];
    bit          cand[2];
    logic [31:0] ea;
    logic        ew;
    logic [2:0]  es;
    logic [5:0]  ep;
    ht[0] = s_i_htrans_i; ht[1] = s_d_htrans_i;
    ad[0] = s_i_haddr_i;  ad[1] = s_d_haddr_i;
    wr[0] = s_i_hwrite_i; wr[1] = s_d_hwrite_i;
    sz[0] = s_i_hsize_i;  sz[1] = s_d_hsize_i;
    par[0] = s_i_hparity_i; par[1] = s_d_hparity_i;
    #1;
    for (int p = 0; p < 2; p++) begin
      rdy[p]  = (own == p) ? s_m_hready_i : !pv[p];
      live[p] = ht[p][1] && rdy[p];
      cand[p] = pv[p] || live[p];
    end
    win = -1;
    if (s_m_hready_i) begin
      if (cand[0] && cand[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (last == 0) ? 1 : 0;
`else
        win = 1;
`endif
      end else if (cand[1]) win = 1;
      else if (cand[0]) win = 0;
    end
    ea = '0; ew = 1'b0; es = '0; ep = '0;
    if (win >= 0) begin
      ea = pv[win] ? pa[win] : ad[win];
      ew = pv[win] ? pw[win] : wr[win];
      es = pv[win] ? ps[win] : sz[win];
      ep = pv[win] ? pp[win] : par[win];
    end
    chk("m_htrans", 32'(s_m_htrans_o), (win >= 0) ? 32'd2 : 32'd0);
    chk("m_haddr", s_m_haddr_o, ea);
    chk("m_hwrite", 32'(s_m_hwrite_o), 32'(ew));
    chk("m_hsize", 32'(s_m_hsize_o), 32'(es));
    chk("m_hparity", 32'(s_m_hparity_o), 32'(ep));
    chk("i_hready", 32'(s_i_hready_o), 32'(rdy[0]));
    chk("d_hready", 32'(s_d_hready_o), 32'(rdy[1]));
    chk("i_hresp", 32'(s_i_hresp_o), (own == 0) ? 32'(s_m_hresp_i) : 32'd0);
    chk("d_hresp", 32'(s_d_hresp_o), (own == 1) ? 32'(s_m_hresp_i) : 32'd0);
    chk("m_hwdata", s_m_hwdata_o, (own == 1) ? s_d_hwdata_i : 32'd0);
    chk("m_hwcsum", 32'(s_m_hwchecksum_o), (own == 1) ? 32'(s_d_hwchecksum_i) : 32'd0);
    chk("hrdata", s_hrdata_o, s_m_hrdata_i);
    chk("hrcsum", 32'(s_hrchecksum_o), 32'(s_m_hrchecksum_i));
  endtask

  // Commit the model's view of this cycle and move to the next falling edge.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      if (win == p) begin
        pv[p] = 1'b0;
      end else if (live[p]) begin
        pv[p] = 1'b1;
        pa[p] = ad[p]; pw[p] = wr[p]; ps[p] = sz[p]; pp[p] = par[p];
      end
    end
    if (s_m_hready_i) own = win;
    if (win >= 0) last = win;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    s_resetn_i = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_htrans", 32'(s_m_htrans_o), 32'd0);
    chk("rst_i_hready", 32'(s_i_hready_o), 32'd1);
    chk("rst_d_hready", 32'(s_d_hready_o), 32'd1);
    chk("rst_i_hresp", 32'(s_i_hresp_o), 32'd0);
    chk("rst_d_hresp", 32'(s_d_hresp_o), 32'd0);
    @(negedge clk);
    s_resetn_i = 1'b1;

    // Fetch alone: zero-latency issue, then owner I follows the bus.
    s_i_htrans_i = 2'b10; s_i_haddr_i = 32'h100;
    check_now();
    chk("tp1_haddr", s_m_haddr_o, 32'h100);
    chk("tp1_htrans", 32'(s_m_htrans_o), 32'd2);
    tick();
    idle_inputs(); s_m_hready_i = 1'b0;
    check_now();
    chk("tp1_i_rdy_lo", 32'(s_i_hready_o), 32'd0);
    tick();
    s_m_hready_i = 1'b1;
    check_now();
    chk("tp1_i_rdy_hi", 32'(s_i_hready_o), 32'd1);
    tick();

    // Conflict: data write wins, fetch buffered and issued next.
    s_i_htrans_i = 2'b10; s_i_haddr_i = 32'h200;
    s_d_htrans_i = 2'b10; s_d_haddr_i = 32'h8000; s_d_hwrite_i = 1'b1;
    check_now();
    chk("tp2_haddr_d", s_m_haddr_o, 32'h8000);
    tick();
    idle_inputs(); s_d_hwdata_i = 32'hCAFE_F00D; s_d_hwchecksum_i = 7'h2A;
    check_now();
    chk("tp2_haddr_i", s_m_haddr_o, 32'h200);
    chk("tp2_i_rdy", 32'(s_i_hready_o), 32'd0);
    chk("tp2_hwdata", s_m_hwdata_o, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    check_now();
    tick();

    // Data request during three bus-wait cycles.
    s_m_hready_i = 1'b0; s_d_htrans_i = 2'b10; s_d_haddr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      check_now();
      chk("tp4_idle", 32'(s_m_htrans_o), 32'd0);
      tick();
      s_d_htrans_i = 2'b00;
    end
    s_m_hready_i = 1'b1;
    check_now();
    chk("tp4_haddr", s_m_haddr_o, 32'h300);
    tick();
    idle_inputs();
    check_now();
    tick();

    // Two-cycle ERROR on a data read while fetch waits in its buffer.
    s_d_htrans_i = 2'b10; s_d_haddr_i = 32'h400;
    s_i_htrans_i = 2'b10; s_i_haddr_i = 32'h500;
    check_now();
    tick();
    idle_inputs(); s_m_hready_i = 1'b0; s_m_hresp_i = 1'b1;
    check_now();
    chk("tp5_d_resp1", 32'(s_d_hresp_o), 32'd1);
    chk("tp5_i_resp1", 32'(s_i_hresp_o), 32'd0);
    tick();
    s_m_hready_i = 1'b1;
    check_now();
    chk("tp5_d_resp2", 32'(s_d_hresp_o), 32'd1);
    chk("tp5_haddr_i", s_m_haddr_o, 32'h500);
    tick();
    idle_inputs();
    check_now();
    tick();

    // Reset with fetch buffered clears everything immediately.
    s_d_htrans_i = 2'b10; s_d_haddr_i = 32'h600;
    s_i_htrans_i = 2'b10; s_i_haddr_i = 32'h700;
    check_now();
    tick();
    idle_inputs();
    #1;
    chk("tp6_pend_rdy", 32'(s_i_hready_o), 32'd0);
    s_resetn_i = 1'b0;
    #1;
    chk("tp6_i_rdy", 32'(s_i_hready_o), 32'd1);
    chk("tp6_htrans", 32'(s_m_htrans_o), 32'd0);
    model_reset();
    @(negedge clk);
    s_resetn_i = 1'b1;
    check_now();
    tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s_i_htrans_i = 2'($urandom_range(0, 3));
      s_d_htrans_i = 2'($urandom_range(0, 3));
      s_i_haddr_i = $urandom; s_d_haddr_i = $urandom;
      s_i_hwrite_i = 1'($urandom); s_d_hwrite_i = 1'($urandom);
      s_i_hsize_i = 3'($urandom); s_d_hsize_i = 3'($urandom);
      s_i_hparity_i = 6'($urandom); s_d_hparity_i = 6'($urandom);
      s_d_hwdata_i = $urandom; s_d_hwchecksum_i = 7'($urandom);
      s_m_hrdata_i = $urandom; s_m_hrchecksum_i = 7'($urandom);
      s_m_hready_i = ($urandom_range(0, 3) != 0);
      s_m_hresp_i = ($urandom_range(0, 7) == 0);
      check_now();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
